dmem_bus_bridge: RTL and testbench

Sits directly downstream of the core's data-memory port and turns the core's level-held access (Address, WriteData, MemReadEnable, MemWriteEnable, MemByteEnable) into a valid/ready request channel plus a response channel to data memory. It returns read data and a one-cycle Ack, which drives memory_controller's DataMem_Ack, plus a Stall that holds the core. Writes are posted through a one-entry write buffer. Reads are ordered behind any buffered write.

---
 rtl/dmem_bus_bridge.sv | 187 ++++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's level-held data-memory access onto a valid/ready request
// channel and a response channel, with a one-entry posted write buffer.
module dmem_bus_bridge (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEnable,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Stall,
  output logic        BusError,
  output logic        BusReqValid,
  input  logic        BusReqReady,
  output logic        BusReqWrite,
  output logic [31:0] BusReqAddr,
  output logic [31:0] BusReqData,
  output logic [3:0]  BusReqBE,
  input  logic        BusRspValid,
  input  logic [31:0] BusRspData,
  input  logic        BusRspErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WRSP,
    S_RREQ,
    S_RRSP
  } bus_state_t;

  bus_state_t  state;

  logic        wb_valid;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_be;

  logic        rd_pending;
  logic [31:0] rd_addr;

  logic        sample;
  logic        wr_rsp;
  logic        wr_free;
  logic        wr_take;
  logic        rd_take;
  logic        bad_take;
  logic        rd_want;
  logic [31:0] word_addr;
  logic [31:0] rd_req_addr;
  logic [31:0] wr_src_addr;
  logic [31:0] wr_src_data;
  logic [3:0]  wr_src_be;

  assign Stall = (ReadEnable | WriteEnable) & ~Ack;

  // The held request is ignored during its own Ack cycle and while a read it
  // started is still in flight.
  assign sample    = ~Ack & ~rd_pending;
  assign wr_rsp    = (state == S_WRSP) & BusRspValid;
  assign wr_free   = ~wb_valid | wr_rsp;
  assign wr_take   = sample & WriteEnable & ~ReadEnable & wr_free;
  assign rd_take   = sample & ReadEnable & ~WriteEnable;
  assign bad_take  = sample & ReadEnable & WriteEnable;
  assign rd_want   = rd_pending | rd_take;
  assign word_addr = Address & ~32'h3;

  // A read sampled on the very edge it is issued has not reached rd_addr yet.
  assign rd_req_addr = rd_pending ? rd_addr : word_addr;

  // An empty buffer being loaded this edge is issued straight from the core.
  assign wr_src_addr = wb_valid ? wb_addr : word_addr;
  assign wr_src_data = wb_valid ? wb_data : WriteData;
  assign wr_src_be   = wb_valid ? wb_be   : ByteEnable;

  // NOTE: all state here updates with non-blocking assignments so every
  // branch sees the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      // NOTE: the buffer payload is reset alongside its valid bit; it is a
      // handful of flops, and it keeps the request outputs free of X.
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      wb_be       <= '0;
      rd_pending  <= 1'b0;
      rd_addr     <= '0;
      ReadData    <= '0;
      Ack         <= 1'b0;
      BusError    <= 1'b0;
      BusReqValid <= 1'b0;
      BusReqWrite <= 1'b0;
      BusReqAddr  <= '0;
      BusReqData  <= '0;
      BusReqBE    <= '0;
    end else begin
      Ack      <= 1'b0;
      BusError <= 1'b0;

      // A reload on the write-response edge wins over the clear.
      if (wr_take) begin
        wb_valid <= 1'b1;
        wb_addr  <= word_addr;
        wb_data  <= WriteData;
        wb_be    <= ByteEnable;
        Ack      <= 1'b1;
      end else if (wr_rsp) begin
        wb_valid <= 1'b0;
      end

      if (bad_take) begin
        Ack      <= 1'b1;
        BusError <= 1'b1;
      end

      if (rd_take) begin
        rd_pending <= 1'b1;
        rd_addr    <= word_addr;
      end

      case (state)
        S_IDLE: begin
          if (wb_valid || wr_take) begin
            state       <= S_WREQ;
            BusReqValid <= 1'b1;
            BusReqWrite <= 1'b1;
            BusReqAddr  <= wr_src_addr;
            BusReqData  <= wr_src_data;
            BusReqBE    <= wr_src_be;
          end else if (rd_want) begin
            state       <= S_RREQ;
            BusReqValid <= 1'b1;
            BusReqWrite <= 1'b0;
            BusReqAddr  <= rd_req_addr;
            BusReqData  <= '0;
            BusReqBE    <= 4'hF;
          end
        end
        S_WREQ: begin
          if (BusReqReady) begin
            BusReqValid <= 1'b0;
            state       <= S_WRSP;
          end
        end
        S_WRSP: begin
          if (BusRspValid) begin
            if (BusRspErr) begin
              BusError <= 1'b1;
            end
            if (rd_want) begin
              state       <= S_RREQ;
              BusReqValid <= 1'b1;
              BusReqWrite <= 1'b0;
              BusReqAddr  <= rd_req_addr;
              BusReqData  <= '0;
              BusReqBE    <= 4'hF;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_RREQ: begin
          if (BusReqReady) begin
            BusReqValid <= 1'b0;
            state       <= S_RRSP;
          end
        end
        S_RRSP: begin
          if (BusRspValid) begin
            state      <= S_IDLE;
            rd_pending <= 1'b0;
            Ack        <= 1'b1;
            ReadData   <= BusRspErr ? 32'h0 : BusRspData;
            if (BusRspErr) begin
              BusError <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: the bench plays both core and memory,
// and every expected value below is worked out by hand from the cycle timing.
module tb_dmem_bus_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [3:0]  ByteEnable;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [31:0] ReadData;
  logic        Ack;
  logic        Stall;
  logic        BusError;
  logic        BusReqValid;
  logic        BusReqReady;
  logic        BusReqWrite;
  logic [31:0] BusReqAddr;
  logic [31:0] BusReqData;
  logic [3:0]  BusReqBE;
  logic        BusRspValid;
  logic [31:0] BusRspData;
  logic        BusRspErr;

  int compared   = 0;
  int mismatched = 0;

  dmem_bus_bridge dut (
    .CLK         (CLK),
    .RST         (RST),
    .Address     (Address),
    .WriteData   (WriteData),
    .ByteEnable  (ByteEnable),
    .ReadEnable  (ReadEnable),
    .WriteEnable (WriteEnable),
    .ReadData    (ReadData),
    .Ack         (Ack),
    .Stall       (Stall),
    .BusError    (BusError),
    .BusReqValid (BusReqValid),
    .BusReqReady (BusReqReady),
    .BusReqWrite (BusReqWrite),
    .BusReqAddr  (BusReqAddr),
    .BusReqData  (BusReqData),
    .BusReqBE    (BusReqBE),
    .BusRspValid (BusRspValid),
    .BusRspData  (BusRspData),
    .BusRspErr   (BusRspErr)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge, outputs read at 3.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST         = 1'b0;
    Address     = '0;
    WriteData   = '0;
    ByteEnable  = '0;
    ReadEnable  = 1'b0;
    WriteEnable = 1'b0;
    BusReqReady = 1'b0;
    BusRspValid = 1'b0;
    BusRspData  = '0;
    BusRspErr   = 1'b0;
    #1;
    check32("rst_readdata", ReadData, 32'h0);
    check1 ("rst_ack", Ack, 1'b0);
    check1 ("rst_buserr", BusError, 1'b0);
    check1 ("rst_valid", BusReqValid, 1'b0);
    check1 ("rst_write", BusReqWrite, 1'b0);
    check32("rst_addr", BusReqAddr, 32'h0);
    check32("rst_data", BusReqData, 32'h0);
    check32("rst_be", 32'(BusReqBE), 32'h0);
    check1 ("rst_stall", Stall, 1'b0);
    step();
    step();
    RST = 1'b1;

    // Posted store into an empty buffer.
    step();
    WriteEnable = 1'b1;
    Address     = 32'h0000_1003;
    WriteData   = 32'hA5A5_0000;
    ByteEnable  = 4'b1100;
    BusReqReady = 1'b1;
    #1;
    check1("st_stall_c1", Stall, 1'b1);
    check1("st_ack_c1", Ack, 1'b0);
    step();
    #1;
    check1 ("st_ack_c2", Ack, 1'b1);
    check1 ("st_stall_c2", Stall, 1'b0);
    check1 ("st_valid", BusReqValid, 1'b1);
    check1 ("st_write", BusReqWrite, 1'b1);
    check32("st_addr", BusReqAddr, 32'h0000_1000);
    check32("st_data", BusReqData, 32'hA5A5_0000);
    check32("st_be", 32'(BusReqBE), 32'h0000_000C);
    WriteEnable = 1'b0;
    step();
    BusRspValid = 1'b1;
    #1;
    check1("st_ack_c3", Ack, 1'b0);
    check1("st_valid_c3", BusReqValid, 1'b0);
    step();
    BusRspValid = 1'b0;
    #1;
    check1("st_buserr", BusError, 1'b0);
    check1("st_valid_c4", BusReqValid, 1'b0);

    // Zero-wait load.
    ReadEnable = 1'b1;
    Address    = 32'h0000_2000;
    #1;
    check1("ld_stall_c0", Stall, 1'b1);
    step();
    #1;
    check1 ("ld_valid", BusReqValid, 1'b1);
    check1 ("ld_write", BusReqWrite, 1'b0);
    check32("ld_addr", BusReqAddr, 32'h0000_2000);
    check32("ld_data", BusReqData, 32'h0);
    check32("ld_be", 32'(BusReqBE), 32'h0000_000F);
    check1 ("ld_stall_c1", Stall, 1'b1);
    step();
    BusRspValid = 1'b1;
    BusRspData  = 32'h1234_5678;
    #1;
    check1("ld_valid_c2", BusReqValid, 1'b0);
    check1("ld_stall_c2", Stall, 1'b1);
    check1("ld_ack_c2", Ack, 1'b0);
    step();
    BusRspValid = 1'b0;
    BusRspData  = '0;
    #1;
    check1 ("ld_ack_c3", Ack, 1'b1);
    check32("ld_readdata", ReadData, 32'h1234_5678);
    check1 ("ld_stall_c3", Stall, 1'b0);
    check1 ("ld_buserr", BusError, 1'b0);
    ReadEnable = 1'b0;
    step();
    #1;
    check1("ld_ack_c4", Ack, 1'b0);
    check1("ld_one_read_c4", BusReqValid, 1'b0);
    step();
    #1;
    check1("ld_one_read_c5", BusReqValid, 1'b0);

    // Store then load to the same word with the request channel blocked.
    BusReqReady = 1'b0;
    WriteEnable = 1'b1;
    Address     = 32'h0000_3000;
    WriteData   = 32'hDEAD_BEEF;
    ByteEnable  = 4'hF;
    step();
    #1;
    check1("wr_ack", Ack, 1'b1);
    check1("wr_valid", BusReqValid, 1'b1);
    WriteEnable = 1'b0;
    ReadEnable  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check1 ("wr_hold_valid", BusReqValid, 1'b1);
      check1 ("wr_hold_write", BusReqWrite, 1'b1);
      check32("wr_hold_addr", BusReqAddr, 32'h0000_3000);
      check32("wr_hold_data", BusReqData, 32'hDEAD_BEEF);
      check1 ("wr_hold_ack", Ack, 1'b0);
      check1 ("wr_hold_stall", Stall, 1'b1);
    end
    BusReqReady = 1'b1;
    step();
    BusRspValid = 1'b1;
    #1;
    check1("wr_rsp_valid", BusReqValid, 1'b0);
    check1("wr_rsp_stall", Stall, 1'b1);
    check1("wr_rsp_ack", Ack, 1'b0);
    step();
    BusRspValid = 1'b0;
    #1;
    check1 ("rd_after_valid", BusReqValid, 1'b1);
    check1 ("rd_after_write", BusReqWrite, 1'b0);
    check32("rd_after_addr", BusReqAddr, 32'h0000_3000);
    check32("rd_after_be", 32'(BusReqBE), 32'h0000_000F);
    check32("rd_after_data", BusReqData, 32'h0);
    check1 ("rd_after_stall", Stall, 1'b1);
    step();
    BusRspValid = 1'b1;
    BusRspData  = 32'hCAFE_F00D;
    #1;
    check1("rd_after_hs", BusReqValid, 1'b0);
    step();
    BusRspValid = 1'b0;
    BusRspData  = '0;
    #1;
    check1 ("rd_after_ack", Ack, 1'b1);
    check32("rd_after_readdata", ReadData, 32'hCAFE_F00D);
    ReadEnable = 1'b0;
    step();
    #1;
    check1("rd_after_ack_end", Ack, 1'b0);

    // Back-to-back stores, first response four cycles late.
    WriteEnable = 1'b1;
    Address     = 32'h0000_4000;
    WriteData   = 32'h1111_1111;
    ByteEnable  = 4'hF;
    step();
    #1;
    check1("b2b_ack1", Ack, 1'b1);
    check1("b2b_valid1", BusReqValid, 1'b1);
    Address    = 32'h0000_4006;
    WriteData  = 32'h2222_2222;
    ByteEnable = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check1("b2b_wait_ack", Ack, 1'b0);
      check1("b2b_wait_stall", Stall, 1'b1);
      check1("b2b_wait_valid", BusReqValid, 1'b0);
    end
    BusRspValid = 1'b1;
    #1;
    check1("b2b_rsp_stall", Stall, 1'b1);
    step();
    BusRspValid = 1'b0;
    #1;
    check1("b2b_ack2", Ack, 1'b1);
    check1("b2b_stall2", Stall, 1'b0);
    check1("b2b_valid_ack2", BusReqValid, 1'b0);
    WriteEnable = 1'b0;
    step();
    #1;
    check1 ("b2b_ack2_end", Ack, 1'b0);
    check1 ("b2b_valid2", BusReqValid, 1'b1);
    check1 ("b2b_write2", BusReqWrite, 1'b1);
    check32("b2b_addr2", BusReqAddr, 32'h0000_4004);
    check32("b2b_data2", BusReqData, 32'h2222_2222);
    check32("b2b_be2", 32'(BusReqBE), 32'h0000_0003);
    step();
    BusRspValid = 1'b1;
    step();
    BusRspValid = 1'b0;
    #1;
    check1("b2b_idle", BusReqValid, 1'b0);

    // Read and write asserted together.
    ReadEnable  = 1'b1;
    WriteEnable = 1'b1;
    Address     = 32'h0000_5000;
    step();
    #1;
    check1("ill_ack", Ack, 1'b1);
    check1("ill_buserr", BusError, 1'b1);
    check1("ill_valid", BusReqValid, 1'b0);
    ReadEnable  = 1'b0;
    WriteEnable = 1'b0;
    step();
    #1;
    check1("ill_ack_end", Ack, 1'b0);
    check1("ill_buserr_end", BusError, 1'b0);
    check1("ill_no_bus", BusReqValid, 1'b0);

    // Write error response: one BusError pulse after it, no retry.
    WriteEnable = 1'b1;
    Address     = 32'h0000_6000;
    WriteData   = 32'h6666_6666;
    step();
    WriteEnable = 1'b0;
    step();
    BusRspValid = 1'b1;
    BusRspErr   = 1'b1;
    #1;
    check1("werr_buserr_pre", BusError, 1'b0);
    step();
    BusRspValid = 1'b0;
    BusRspErr   = 1'b0;
    #1;
    check1("werr_buserr", BusError, 1'b1);
    check1("werr_ack", Ack, 1'b0);
    check1("werr_no_retry", BusReqValid, 1'b0);
    step();
    #1;
    check1("werr_buserr_end", BusError, 1'b0);
    check1("werr_no_retry2", BusReqValid, 1'b0);

    // Reset while the write response is outstanding.
    WriteEnable = 1'b1;
    Address     = 32'h0000_7000;
    WriteData   = 32'h7777_7777;
    step();
    WriteEnable = 1'b0;
    step();
    #1;
    check32("mid_addr_pre", BusReqAddr, 32'h0000_7000);
    RST = 1'b0;
    #1;
    check1 ("mid_valid", BusReqValid, 1'b0);
    check1 ("mid_ack", Ack, 1'b0);
    check1 ("mid_write", BusReqWrite, 1'b0);
    check32("mid_addr", BusReqAddr, 32'h0);
    check32("mid_data", BusReqData, 32'h0);
    check32("mid_readdata", ReadData, 32'h0);
    step();
    RST         = 1'b1;
    BusRspValid = 1'b1;
    BusRspErr   = 1'b1;
    step();
    BusRspValid = 1'b0;
    BusRspErr   = 1'b0;
    #1;
    check1("mid_stale_buserr", BusError, 1'b0);
    check1("mid_stale_ack", Ack, 1'b0);
    check1("mid_buf_gone", BusReqValid, 1'b0);
    step();
    #1;
    check1("mid_buf_gone2", BusReqValid, 1'b0);

    ReadEnable = 1'b1;
    Address    = 32'h0000_8004;
    step();
    #1;
    check1 ("post_valid", BusReqValid, 1'b1);
    check32("post_addr", BusReqAddr, 32'h0000_8004);
    step();
    BusRspValid = 1'b1;
    BusRspData  = 32'h0BAD_F00D;
    step();
    BusRspValid = 1'b0;
    BusRspData  = '0;
    #1;
    check1 ("post_ack", Ack, 1'b1);
    check32("post_readdata", ReadData, 32'h0BAD_F00D);
    ReadEnable = 1'b0;
    step();

    // Read error response.
    ReadEnable = 1'b1;
    Address    = 32'h0000_9000;
    step();
    #1;
    check1("rerr_valid", BusReqValid, 1'b1);
    step();
    BusRspValid = 1'b1;
    BusRspErr   = 1'b1;
    BusRspData  = 32'hFFFF_FFFF;
    step();
    BusRspValid = 1'b0;
    BusRspErr   = 1'b0;
    BusRspData  = '0;
    #1;
    check1 ("rerr_ack", Ack, 1'b1);
    check1 ("rerr_buserr", BusError, 1'b1);
    check32("rerr_readdata", ReadData, 32'h0);
    ReadEnable = 1'b0;
    step();
    #1;
    check1("rerr_ack_end", Ack, 1'b0);
    check1("rerr_buserr_end", BusError, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
